alu_exec_unit: RTL and testbench

//  ALU execution core; the responder on the ALU input/output interfaces that the env driver stimulates and the monitor samples.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_mul_seq.sv | 69 ++++++
 rtl/alu_exec_unit.sv | 157 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, operand-select and FSM types for the ALU execution unit
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_SHL  = 4'h3,
        OP_SHR  = 4'h4,
        OP_ROL  = 4'h5,
        OP_ROR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NAND = 4'hB,
        OP_NOR  = 4'hC,
        OP_XNOR = 4'hD,
        OP_INC  = 4'hE,
        OP_DEC  = 4'hF
    } alu_op_t;

    typedef enum logic [1:0] {
        MOVI_REG_B   = 2'b00,
        MOVI_MEM     = 2'b01,
        MOVI_IMM     = 2'b10,
        MOVI_IMM_ALT = 2'b11
    } movi_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add unsigned multiplier, one partial product per clock
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     multiplicand,
    input  logic [DATA_WIDTH-1:0]     multiplier,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH);

    logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
    logic [DATA_WIDTH-1:0]   mplr_q, mplr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;

    // Counter parks at CNT_LAST; done stays up until the cycle it is consumed.
    assign done    = busy_q && (cnt_q == CNT_LAST);
    assign product = prod_q;

    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start) begin
            mcand_d = {{DATA_WIDTH{1'b0}}, multiplicand};
            mplr_d  = multiplier;
            prod_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (done) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            if (mplr_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execution core: operand select, single-cycle datapath, MUL sequencing FSM
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ACT,
    input  logic [3:0]                OP,
    input  logic [1:0]                MOVI,
    input  logic [DATA_WIDTH-1:0]     REG_A,
    input  logic [DATA_WIDTH-1:0]     REG_B,
    input  logic [DATA_WIDTH-1:0]     MEM,
    input  logic [DATA_WIDTH-1:0]     IMM,
    output logic                      ALU_RDY,
    output logic [2*DATA_WIDTH-1:0]   EX_ALU,
    output logic                      EX_ALU_VLD
);

    localparam int          N       = DATA_WIDTH;
    localparam int          W2      = 2 * DATA_WIDTH;
    localparam logic [N:0]  ONE_EXT = {{N{1'b0}}, 1'b1};

    alu_op_t    op_in;
    alu_op_t    op_q, op_d;
    alu_state_t state_q, state_d;
    logic [N-1:0]  b_sel;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic          issue_q, issue_d;
    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;
    logic [W2-1:0] ex_alu_q, ex_alu_d;
    logic [W2-1:0] alu_res;
    logic [W2-1:0] mul_product;
    logic          accept, mul_start, mul_done;
    logic [N:0]    a_ext, b_ext;

    assign op_in     = alu_op_t'(OP);
    assign accept    = ACT && rdy_q;
    assign mul_start = accept && (op_in == OP_MUL);

    always_comb begin
        b_sel = IMM;
        case (movi_t'(MOVI))
            MOVI_REG_B: b_sel = REG_B;
            MOVI_MEM:   b_sel = MEM;
            default:    b_sel = IMM;
        endcase
    end

    assign a_ext = {1'b0, a_q};
    assign b_ext = {1'b0, b_q};

    // Operates on operands captured at accept, so inputs may change freely afterwards.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = {{(N-1){1'b0}}, a_ext + b_ext};
            OP_SUB:  alu_res = {{(N-1){1'b0}}, a_ext - b_ext};
            OP_SHL:  alu_res = {{N{1'b0}}, a_q << 1};
            OP_SHR:  alu_res = {{N{1'b0}}, a_q >> 1};
            OP_ROL:  alu_res = {{N{1'b0}}, a_q[N-2:0], a_q[N-1]};
            OP_ROR:  alu_res = {{N{1'b0}}, a_q[0], a_q[N-1:1]};
            OP_NOT:  alu_res = {{N{1'b0}}, ~a_q};
            OP_AND:  alu_res = {{N{1'b0}}, a_q & b_q};
            OP_OR:   alu_res = {{N{1'b0}}, a_q | b_q};
            OP_XOR:  alu_res = {{N{1'b0}}, a_q ^ b_q};
            OP_NAND: alu_res = {{N{1'b0}}, ~(a_q & b_q)};
            OP_NOR:  alu_res = {{N{1'b0}}, ~(a_q | b_q)};
            OP_XNOR: alu_res = {{N{1'b0}}, ~(a_q ^ b_q)};
            OP_INC:  alu_res = {{(N-1){1'b0}}, a_ext + ONE_EXT};
            OP_DEC:  alu_res = {{(N-1){1'b0}}, a_ext - ONE_EXT};
            default: alu_res = '0;
        endcase
    end

    alu_mul_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk          (CLK),
        .rst_n        (RST),
        .start        (mul_start),
        .multiplicand (REG_A),
        .multiplier   (b_sel),
        .done         (mul_done),
        .product      (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        rdy_d    = rdy_q;
        vld_d    = 1'b0;
        ex_alu_d = ex_alu_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        issue_d  = accept && (op_in != OP_MUL);
        if (accept) begin
            op_d = op_in;
            a_d  = REG_A;
            b_d  = b_sel;
        end
        case (state_q)
            ST_IDLE: begin
                rdy_d = 1'b1;
                if (issue_q) begin
                    ex_alu_d = alu_res;
                    vld_d    = 1'b1;
                end
                if (mul_start) begin
                    state_d = ST_MUL_BUSY;
                    rdy_d   = 1'b0;
                end
            end
            ST_MUL_BUSY: begin
                rdy_d = 1'b0;
                if (mul_done) begin
                    ex_alu_d = mul_product;
                    vld_d    = 1'b1;
                    rdy_d    = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
            ex_alu_q <= '0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            issue_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
            ex_alu_q <= ex_alu_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            issue_q  <= issue_d;
        end
    end

    assign ALU_RDY    = rdy_q;
    assign EX_ALU     = ex_alu_q;
    assign EX_ALU_VLD = vld_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed vector table plus multi-cycle sequences for alu_exec_unit
module tb_alu_exec_unit;

    logic        CLK;
    logic        RST;
    logic        ACT;
    logic [3:0]  OP;
    logic [1:0]  MOVI;
    logic [7:0]  REG_A, REG_B, MEM, IMM;
    logic        ALU_RDY;
    logic [15:0] EX_ALU;
    logic        EX_ALU_VLD;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ACT        (ACT),
        .OP         (OP),
        .MOVI       (MOVI),
        .REG_A      (REG_A),
        .REG_B      (REG_B),
        .MEM        (MEM),
        .IMM        (IMM),
        .ALU_RDY    (ALU_RDY),
        .EX_ALU     (EX_ALU),
        .EX_ALU_VLD (EX_ALU_VLD)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  movi;
        logic [7:0]  a;
        logic [7:0]  rb;
        logic [7:0]  mem;
        logic [7:0]  imm;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [25];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai = int'(a);
        int bi = int'(b);
        int r;
        case (op)
            4'h0: r = ai + bi;
            4'h1: r = (ai - bi) & 'h1FF;
            4'h2: r = ai * bi;
            4'h3: r = (ai * 2) & 255;
            4'h4: r = ai / 2;
            4'h5: r = ((ai * 2) & 255) + (ai / 128);
            4'h6: r = (ai / 2) + ((ai % 2) * 128);
            4'h7: r = 255 - ai;
            4'h8: r = ai & bi;
            4'h9: r = ai | bi;
            4'hA: r = ai ^ bi;
            4'hB: r = 255 - (ai & bi);
            4'hC: r = 255 - (ai | bi);
            4'hD: r = 255 - (ai ^ bi);
            4'hE: r = ai + 1;
            default: r = (ai - 1) & 'h1FF;
        endcase
        return r[15:0];
    endfunction

    task automatic run_op(input string name, input logic [3:0] op, input logic [1:0] movi,
                          input logic [7:0] a, input logic [7:0] rb, input logic [7:0] mem,
                          input logic [7:0] imm, input logic [15:0] exp);
        int lat;
        int exp_lat;
        OP = op; MOVI = movi; REG_A = a; REG_B = rb; MEM = mem; IMM = imm; ACT = 1'b1;
        check({name, "_rdy"}, 32'(ALU_RDY), 32'd1);
        step();
        ACT = 1'b0;
        OP = ~op; MOVI = ~movi; REG_A = ~a; REG_B = ~rb; MEM = ~mem; IMM = ~imm;
        check({name, "_vld_early"}, 32'(EX_ALU_VLD), 32'd0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (EX_ALU_VLD) begin
                lat = i;
                break;
            end
        end
        exp_lat = (op == 4'h2) ? 9 : 1;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, 32'(EX_ALU), 32'(exp));
        step();
        check({name, "_vld_drop"}, 32'(EX_ALU_VLD), 32'd0);
        check({name, "_hold"}, 32'(EX_ALU), 32'(exp));
    endtask

    initial begin
        logic       seen_vld;
        logic [3:0] r_op;
        logic [1:0] r_movi;
        logic [7:0] r_a, r_rb, r_mem, r_imm, r_b;

        vecs[0]  = '{4'h0, 2'b00, 8'hFF, 8'h01, 8'h55, 8'hAA, 16'h0100};
        vecs[1]  = '{4'h1, 2'b10, 8'h00, 8'h07, 8'h09, 8'h01, 16'h01FF};
        vecs[2]  = '{4'h0, 2'b01, 8'h10, 8'h77, 8'h22, 8'h99, 16'h0032};
        vecs[3]  = '{4'h0, 2'b11, 8'h10, 8'h77, 8'h66, 8'h05, 16'h0015};
        vecs[4]  = '{4'h1, 2'b00, 8'h50, 8'h20, 8'h01, 8'h02, 16'h0030};
        vecs[5]  = '{4'h3, 2'b00, 8'h41, 8'h00, 8'h00, 8'h00, 16'h0082};
        vecs[6]  = '{4'h4, 2'b00, 8'h81, 8'h00, 8'h00, 8'h00, 16'h0040};
        vecs[7]  = '{4'h5, 2'b00, 8'h81, 8'h00, 8'h00, 8'h00, 16'h0003};
        vecs[8]  = '{4'h6, 2'b00, 8'h81, 8'h00, 8'h00, 8'h00, 16'h00C0};
        vecs[9]  = '{4'h7, 2'b00, 8'h0F, 8'h00, 8'h00, 8'h00, 16'h00F0};
        vecs[10] = '{4'h8, 2'b00, 8'h0F, 8'h3C, 8'hFF, 8'hFF, 16'h000C};
        vecs[11] = '{4'h9, 2'b01, 8'h0F, 8'h00, 8'h3C, 8'h00, 16'h003F};
        vecs[12] = '{4'hA, 2'b10, 8'h0F, 8'hFF, 8'hFF, 8'h3C, 16'h0033};
        vecs[13] = '{4'hB, 2'b11, 8'h0F, 8'h00, 8'h00, 8'h3C, 16'h00F3};
        vecs[14] = '{4'hC, 2'b00, 8'h0F, 8'h3C, 8'h00, 8'h00, 16'h00C0};
        vecs[15] = '{4'hD, 2'b01, 8'h0F, 8'h00, 8'h3C, 8'h00, 16'h00CC};
        vecs[16] = '{4'hE, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 16'h0100};
        vecs[17] = '{4'hF, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h01FF};
        vecs[18] = '{4'hE, 2'b10, 8'h12, 8'h00, 8'h00, 8'h00, 16'h0013};
        vecs[19] = '{4'hF, 2'b01, 8'h80, 8'h00, 8'h00, 8'h00, 16'h007F};
        vecs[20] = '{4'h2, 2'b01, 8'hFF, 8'h00, 8'hFF, 8'h00, 16'hFE01};
        vecs[21] = '{4'h2, 2'b10, 8'h0D, 8'h00, 8'h00, 8'h0B, 16'h008F};
        vecs[22] = '{4'h2, 2'b00, 8'h00, 8'h37, 8'h00, 8'h00, 16'h0000};
        vecs[23] = '{4'h2, 2'b11, 8'h80, 8'h00, 8'h00, 8'h02, 16'h0100};
        vecs[24] = '{4'h1, 2'b01, 8'h05, 8'h00, 8'h05, 8'h00, 16'h0000};

        RST = 1'b0; ACT = 1'b0; OP = '0; MOVI = '0;
        REG_A = '0; REG_B = '0; MEM = '0; IMM = '0;

        repeat (3) step();
        check("reset_ex_alu", 32'(EX_ALU), 32'd0);
        check("reset_vld", 32'(EX_ALU_VLD), 32'd0);
        check("reset_rdy", 32'(ALU_RDY), 32'd0);
        RST = 1'b1;
        #1;
        check("rdy_before_first_edge", 32'(ALU_RDY), 32'd0);
        step();
        check("rdy_after_first_edge", 32'(ALU_RDY), 32'd1);
        check("vld_after_release", 32'(EX_ALU_VLD), 32'd0);

        for (int i = 0; i < 25; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].movi, vecs[i].a,
                   vecs[i].rb, vecs[i].mem, vecs[i].imm, vecs[i].exp);
        end

        OP = 4'h2; MOVI = 2'b01; REG_A = 8'hFF; MEM = 8'hFF; ACT = 1'b1;
        step();
        ACT = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                OP = 4'h0; MOVI = 2'b00; REG_A = 8'h02; REG_B = 8'h03; ACT = 1'b1;
            end
            step();
            ACT = 1'b0;
            check($sformatf("mul_busy_rdy_t%0d", i), 32'(ALU_RDY), 32'd0);
            check($sformatf("mul_busy_vld_t%0d", i), 32'(EX_ALU_VLD), 32'd0);
        end
        step();
        check("mul_done_vld", 32'(EX_ALU_VLD), 32'd1);
        check("mul_done_result", 32'(EX_ALU), 32'hFE01);
        check("mul_done_rdy", 32'(ALU_RDY), 32'd1);
        OP = 4'h0; MOVI = 2'b00; REG_A = 8'h02; REG_B = 8'h03; ACT = 1'b1;
        step();
        ACT = 1'b0;
        check("ignored_act_no_vld", 32'(EX_ALU_VLD), 32'd0);
        check("ignored_act_hold", 32'(EX_ALU), 32'hFE01);
        step();
        check("after_mul_add_vld", 32'(EX_ALU_VLD), 32'd1);
        check("after_mul_add_result", 32'(EX_ALU), 32'h0005);

        OP = 4'h8; MOVI = 2'b00; REG_A = 8'h0F; REG_B = 8'h3C; ACT = 1'b1;
        step();
        OP = 4'hA;
        step();
        check("b2b_and_vld", 32'(EX_ALU_VLD), 32'd1);
        check("b2b_and", 32'(EX_ALU), 32'h000C);
        OP = 4'h5; REG_A = 8'h81;
        step();
        ACT = 1'b0;
        check("b2b_xor_vld", 32'(EX_ALU_VLD), 32'd1);
        check("b2b_xor", 32'(EX_ALU), 32'h0033);
        step();
        check("b2b_rol_vld", 32'(EX_ALU_VLD), 32'd1);
        check("b2b_rol", 32'(EX_ALU), 32'h0003);
        step();
        check("b2b_end_vld", 32'(EX_ALU_VLD), 32'd0);

        OP = 4'h2; MOVI = 2'b01; REG_A = 8'hFF; MEM = 8'hFF; ACT = 1'b1;
        step();
        ACT = 1'b0;
        repeat (4) step();
        RST = 1'b0;
        #1;
        check("midmul_reset_ex_alu", 32'(EX_ALU), 32'd0);
        check("midmul_reset_vld", 32'(EX_ALU_VLD), 32'd0);
        check("midmul_reset_rdy", 32'(ALU_RDY), 32'd0);
        repeat (2) step();
        RST = 1'b1;
        #1;
        check("midmul_release_rdy_low", 32'(ALU_RDY), 32'd0);
        step();
        check("midmul_release_rdy_high", 32'(ALU_RDY), 32'd1);
        seen_vld = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (EX_ALU_VLD) seen_vld = 1'b1;
        end
        check("midmul_no_late_vld", 32'(seen_vld), 32'd0);
        run_op("post_reset_add", 4'h0, 2'b00, 8'h02, 8'h03, 8'h40, 8'h80, 16'h0005);

        for (int i = 0; i < 30; i++) begin
            r_op   = 4'($urandom_range(0, 15));
            r_movi = 2'($urandom_range(0, 3));
            r_a    = 8'($urandom_range(0, 255));
            r_rb   = 8'($urandom_range(0, 255));
            r_mem  = 8'($urandom_range(0, 255));
            r_imm  = 8'($urandom_range(0, 255));
            r_b    = (r_movi == 2'b00) ? r_rb : (r_movi == 2'b01) ? r_mem : r_imm;
            run_op($sformatf("rand%0d_op%0h", i, r_op), r_op, r_movi, r_a, r_rb, r_mem, r_imm,
                   ref_model(r_op, r_a, r_b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
